aes_key_schedule: RTL and testbench

Parametrised successor to the AES-128 key expansion block: accepts a 128/192/256-bit cipher key via a valid/ready load handshake and streams the Nr+1 round keys (11/13/15) in encryption order over a valid/ready output, with Rcon generated internally. It sits between the key-load interface and the round datapath. The round datapath consumes one round key per handshake and may backpressure at any time.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_key_schedule_if.sv | 28 ++
 rtl/aes_subword.sv | 28 ++
 rtl/aes_key_schedule.sv | 122 ++++++++++++
 tb/tb_aes_key_schedule.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key length encodings, FSM states, round-count lookups and GF(2^8) xtime.
package aes_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned RK_W    = 128;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned LEN_W   = 2;
    localparam int unsigned WIN_LEN = 8;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2,
        KEY_RSV = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            2'd0:    return 4'd4;
            2'd1:    return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            2'd0:    return 4'd10;
            2'd1:    return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-load and round-key stream bundle between the key source, the schedule and the round datapath.
interface aes_key_schedule_if
    import aes_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS = 256
);
    logic                    load_valid;
    logic                    load_ready;
    logic [LEN_W-1:0]        key_len;
    logic [MAX_KEY_BITS-1:0] key_in;
    logic                    rk_valid;
    logic                    rk_ready;
    logic [RK_W-1:0]         rk_data;
    logic [IDX_W-1:0]        rk_index;
    logic                    rk_last;
    logic                    busy;
    logic                    len_err;

    modport master (
        output load_valid, key_len, key_in, rk_ready,
        input  load_ready, rk_valid, rk_data, rk_index, rk_last, busy, len_err
    );

    modport slave (
        input  load_valid, key_len, key_in, rk_ready,
        output load_ready, rk_valid, rk_data, rk_index, rk_last, busy, len_err
    );
endinterface

// File: rtl/aes_subword.sv
// Combinational AES SubWord: forward S-box applied to each of the four bytes of a word.
module aes_subword (
    input  logic [31:0] data,
    output logic [31:0] result
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign result[8*b +: 8] = SBOX[data[8*b +: 8]];
    end
endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion: one schedule word per cycle, round keys streamed over valid/ready.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS = 256
) (
    input logic              clk,
    input logic              rst,
    aes_key_schedule_if.slave bus
);
    state_e                         state;
    logic [WIN_LEN-1:0][WORD_W-1:0] key_r;
    logic [WIN_LEN-1:0][WORD_W-1:0] win;
    logic [2:0][WORD_W-1:0]         acc;
    logic [CNT_W-1:0]               i;
    logic [2:0]                     j;
    logic [7:0]                     rcon;
    logic [3:0]                     nk_r;
    logic [3:0]                     nr_r;

    logic [WORD_W-1:0] prev_w, far_w, sub_in, sub_out, t_w, w_new;
    logic              key_done, rk_fire, advance, last_word, len_ok;

    aes_subword u_subword (
        .data   (sub_in),
        .result (sub_out)
    );

    // Next schedule word; words are byte-0-low, so RotWord is a right rotate by one byte.
    always_comb begin
        prev_w    = win[0];
        far_w     = win[3'(nk_r - 4'd1)];
        sub_in    = (j == 3'd0) ? {prev_w[7:0], prev_w[31:8]} : prev_w;
        t_w       = prev_w;
        if (j == 3'd0) begin
            t_w = sub_out ^ {24'h0, rcon};
        end else if (nk_r == 4'd8 && j == 3'd4) begin
            t_w = sub_out;
        end
        w_new     = (i < CNT_W'(nk_r)) ? key_r[i[2:0]] : (far_w ^ t_w);
        key_done  = (i[1:0] == 2'b11);
        rk_fire   = bus.rk_valid && bus.rk_ready;
        advance   = (state == ST_GEN) && !(key_done && bus.rk_valid && !bus.rk_ready);
        last_word = (i == {nr_r, 2'b11});
        len_ok    = (key_len_e'(bus.key_len) != KEY_RSV)
                 && ((32'(nk_of(bus.key_len)) << 5) <= 32'(MAX_KEY_BITS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bus.load_ready <= 1'b1;
            bus.busy     <= 1'b0;
            bus.len_err  <= 1'b0;
            bus.rk_valid <= 1'b0;
            bus.rk_data  <= '0;
            bus.rk_index <= '0;
            bus.rk_last  <= 1'b0;
            key_r        <= '0;
            win          <= '0;
            acc          <= '0;
            i            <= '0;
            j            <= '0;
            rcon         <= '0;
            nk_r         <= '0;
            nr_r         <= '0;
        end else begin
            bus.len_err <= 1'b0;
            if (rk_fire) begin
                bus.rk_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.load_valid) begin
                        if (len_ok) begin
                            key_r          <= 256'(bus.key_in);
                            nk_r           <= nk_of(bus.key_len);
                            nr_r           <= nr_of(bus.key_len);
                            i              <= '0;
                            j              <= '0;
                            rcon           <= 8'h01;
                            state          <= ST_GEN;
                            bus.load_ready <= 1'b0;
                            bus.busy       <= 1'b1;
                        end else begin
                            bus.len_err <= 1'b1;
                        end
                    end
                end
                ST_GEN: begin
                    if (advance) begin
                        win <= {win[WIN_LEN-2:0], w_new};
                        acc <= {acc[1:0], w_new};
                        i   <= i + CNT_W'(1);
                        j   <= (j == 3'(nk_r - 4'd1)) ? 3'd0 : j + 3'd1;
                        if (i >= CNT_W'(nk_r) && j == 3'd0) begin
                            rcon <= xtime(rcon);
                        end
                        // Fourth word completes a round key: publish it, oldest word in the low lane.
                        if (key_done) begin
                            bus.rk_valid <= 1'b1;
                            bus.rk_data  <= {w_new, acc[0], acc[1], acc[2]};
                            bus.rk_index <= i[5:2];
                            bus.rk_last  <= (i[5:2] == nr_r);
                        end
                        if (last_word) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rk_fire && bus.rk_last) begin
                        state          <= ST_IDLE;
                        bus.load_ready <= 1'b1;
                        bus.busy       <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 key expansion vectors, backpressure, length errors, reset.
module tb_aes_key_schedule;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_key_schedule_if #(.MAX_KEY_BITS(256)) bus ();
    aes_key_schedule_if #(.MAX_KEY_BITS(128)) bus_s ();

    aes_key_schedule #(.MAX_KEY_BITS(256)) dut (.clk(clk), .rst(rst), .bus(bus));
    aes_key_schedule #(.MAX_KEY_BITS(128)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // FIPS-197 hex strings are byte 0 first; the DUT bus puts byte 0 in the low lane.
    function automatic logic [127:0] le128(input logic [127:0] x);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = x[8*(15-b) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] le256(input logic [255:0] x);
        logic [255:0] r;
        for (int b = 0; b < 32; b++) r[8*b +: 8] = x[8*(31-b) +: 8];
        return r;
    endfunction

    logic [127:0] e128 [11] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };

    logic [255:0] key128, key192, key256;

    logic [127:0] got_key  [16];
    int           got_idx  [16];
    bit           got_last [16];
    int           n_got;
    int           last_rel;

    // Load a key, then act as the round datapath with rk_ready high pct% of cycles.
    task automatic run_sched(input logic [1:0] len, input logic [255:0] key, input int pct,
                             input bit intrude, input int stop_after);
        bit           done, stalled, rdy;
        logic [127:0] held_data;
        logic [5:0]   held_ctl;
        int           rel;
        n_got    = 0;
        last_rel = -1;
        done     = 1'b0;
        stalled  = 1'b0;
        @(negedge clk);
        chk("load_ready_before_load", 128'(bus.load_ready), 128'(1));
        bus.load_valid = 1'b1;
        bus.key_len    = len;
        bus.key_in     = key;
        bus.rk_ready   = 1'b0;
        @(posedge clk);
        rel = 0;
        while (!done && rel < 400) begin
            @(negedge clk);
            bus.load_valid = intrude && (rel == 8);
            if (intrude && rel == 8) begin
                bus.key_len = 2'd1;
                bus.key_in  = '1;
            end
            if (rel == 0) begin
                chk("busy_after_load", 128'({bus.busy, bus.load_ready}), 128'(2'b10));
            end
            if (stalled) begin
                chk("stall_data", bus.rk_data, held_data);
                chk("stall_ctl", 128'({bus.rk_valid, bus.rk_index, bus.rk_last}), 128'(held_ctl));
            end
            rdy          = ($urandom_range(99) < pct);
            bus.rk_ready = rdy;
            if (bus.rk_valid && rdy && n_got < 16) begin
                got_key[n_got]  = bus.rk_data;
                got_idx[n_got]  = int'(bus.rk_index);
                got_last[n_got] = bus.rk_last;
                n_got++;
                if (bus.rk_last) begin
                    last_rel = rel;
                    done     = 1'b1;
                end
                if (stop_after != 0 && n_got == stop_after) done = 1'b1;
            end
            stalled   = bus.rk_valid && !rdy;
            held_data = bus.rk_data;
            held_ctl  = {bus.rk_valid, bus.rk_index, bus.rk_last};
            rel++;
        end
        if (!done) chk("schedule_timeout", 128'(0), 128'(1));
        if (stop_after == 0) begin
            @(negedge clk);
            bus.rk_ready = 1'b0;
            chk("idle_after_last", 128'({bus.load_ready, bus.busy, bus.rk_valid}), 128'(3'b100));
        end
    endtask

    task automatic verify128(input string tag, input bit timed);
        chk({tag, "_count"}, 128'(n_got), 128'(11));
        for (int n = 0; n < 11 && n < n_got; n++) begin
            chk($sformatf("%s_key%0d", tag, n), got_key[n], le128(e128[n]));
            chk($sformatf("%s_idx%0d", tag, n), 128'({got_idx[n], got_last[n]}), 128'({n, (n == 10)}));
        end
        if (timed) chk({tag, "_last_at"}, 128'(last_rel), 128'(44));
    endtask

    initial begin
        key128 = le256({128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0});
        key192 = le256({192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0});
        key256 = le256(256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4);
        bus.load_valid   = 1'b0;
        bus.key_len      = 2'd0;
        bus.key_in       = '0;
        bus.rk_ready     = 1'b0;
        bus_s.load_valid = 1'b0;
        bus_s.key_len    = 2'd0;
        bus_s.key_in     = '0;
        bus_s.rk_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 128'({bus.load_ready, bus.rk_valid, bus.busy, bus.len_err, bus.rk_last, bus.rk_index}),
            128'(9'b1_0000_0000));
        chk("reset_data", bus.rk_data, 128'h0);
        rst = 1'b0;

        run_sched(2'd0, key128, 100, 1'b0, 0);
        verify128("a128", 1'b1);

        run_sched(2'd1, key192, 100, 1'b0, 0);
        chk("a192_count", 128'(n_got), 128'(13));
        chk("a192_key0", got_key[0], le128(128'h8e73b0f7_da0e6452_c810f32b_809079e5));
        chk("a192_key12", got_key[12], le128(128'he98ba06f_448c773c_8ecc7204_01002202));
        chk("a192_idx12", 128'({got_idx[12], got_last[12]}), 128'({12, 1'b1}));
        chk("a192_last_at", 128'(last_rel), 128'(52));

        run_sched(2'd2, key256, 100, 1'b0, 0);
        chk("a256_count", 128'(n_got), 128'(15));
        chk("a256_key0", got_key[0], le128(128'h603deb10_15ca71be_2b73aef0_857d7781));
        chk("a256_key1", got_key[1], le128(128'h1f352c07_3b6108d7_2d9810a3_0914dff4));
        chk("a256_key14", got_key[14], le128(128'hfe4890d1_e6188d0b_046df344_706c631e));
        chk("a256_idx14", 128'({got_idx[14], got_last[14]}), 128'({14, 1'b1}));
        chk("a256_last_at", 128'(last_rel), 128'(60));

        // Random backpressure, with a stray load attempt in the middle of generation.
        run_sched(2'd0, key128, 30, 1'b1, 0);
        verify128("bp128", 1'b0);

        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.key_len    = 2'd3;
        bus_s.load_valid = 1'b1;
        bus_s.key_len    = 2'd2;
        @(posedge clk);
        @(negedge clk);
        bus.load_valid   = 1'b0;
        bus_s.load_valid = 1'b0;
        chk("rsv_len_err", 128'({bus.len_err, bus.rk_valid, bus.load_ready, bus.busy}), 128'(4'b1010));
        chk("k256_on_128_len_err", 128'({bus_s.len_err, bus_s.rk_valid, bus_s.load_ready, bus_s.busy}),
            128'(4'b1010));
        @(negedge clk);
        chk("len_err_one_cycle", 128'({bus.len_err, bus_s.len_err, bus.rk_valid, bus_s.rk_valid}), 128'(0));
        bus_s.load_valid = 1'b1;
        bus_s.key_len    = 2'd0;
        bus_s.key_in     = key128[127:0];
        bus_s.rk_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_s.load_valid = 1'b0;
        chk("k128_on_128_accepted", 128'({bus_s.busy, bus_s.load_ready, bus_s.len_err}), 128'(3'b100));

        // Abort through reset once key 5 has been handed over.
        run_sched(2'd0, key128, 100, 1'b0, 6);
        chk("pre_reset_key5", got_key[5], le128(e128[5]));
        @(posedge clk);
        @(negedge clk);
        bus.rk_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset_state", 128'({bus.rk_valid, bus.load_ready, bus.busy}), 128'(3'b010));
        chk("mid_reset_data", bus.rk_data, 128'h0);
        rst = 1'b0;
        run_sched(2'd0, key128, 100, 1'b0, 0);
        verify128("post_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
